// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem word fetches, buffers returned words and feeds decode.
// Optional macro FETCH_PERF_EN adds perf_fetched/perf_flushes event counters.
module if_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt;
  logic [AW-1:0] q_wr;
  logic [AW-1:0] q_rd;
  logic [AW-1:0] t_wr;
  logic [AW-1:0] t_rd;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] tag_pc  [DEPTH];

  logic [SW-1:0] inflight;
  logic          req_fire;
  logic          rsp_fire;
  logic          id_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] disc;
  logic [CW-1:0] count_n;
  logic [AW-1:0] q_rd_n;
  logic [31:0]   head_instr_n;
  logic [31:0]   head_pc_n;

  // Credit rule: queued plus in-flight words never exceed the queue depth.
  assign inflight       = SW'(count) + SW'(outstanding);
  assign imem_req_valid = rst & (state == FETCH) & (inflight < SW'(DEPTH));
  assign imem_addr      = pc;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid & (outstanding != '0);
  assign id_fire  = id_valid & id_ready;
  assign push     = rsp_fire & (state == FETCH) & ~redirect;
  assign pop      = id_fire & ~redirect;
  assign disc     = outstanding + CW'(req_fire) - CW'(rsp_fire);

  // Next queue occupancy and the head entry decode will see next cycle.
  always_comb begin
    count_n      = count;
    q_rd_n       = q_rd;
    head_instr_n = id_instr;
    head_pc_n    = id_pc;
    if (redirect) begin
      count_n = '0;
      q_rd_n  = '0;
    end else begin
      count_n = count + CW'(push) - CW'(pop);
      if (pop) begin
        q_rd_n = q_rd + AW'(1);
      end
    end
    if (count_n != '0) begin
      if (push && (q_wr == q_rd_n)) begin
        head_instr_n = imem_rsp_data;
        head_pc_n    = tag_pc[t_rd];
      end else begin
        head_instr_n = q_instr[q_rd_n];
        head_pc_n    = q_pc[q_rd_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      t_wr        <= '0;
      t_rd        <= '0;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
    end else begin
      outstanding <= disc;
      count       <= count_n;
      q_rd        <= q_rd_n;
      id_valid    <= (count_n != '0);
      id_instr    <= head_instr_n;
      id_pc       <= head_pc_n;

      if (redirect) begin
        q_wr <= '0;
      end else if (push) begin
        q_wr <= q_wr + AW'(1);
      end

      // Tag pointers track every in-flight request, including discarded ones.
      if (req_fire) begin
        t_wr <= t_wr + AW'(1);
      end
      if (rsp_fire) begin
        t_rd <= t_rd + AW'(1);
      end

      if (redirect) begin
        pc <= redirect_pc & ~32'd3;
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end

      case (state)
        FETCH: begin
          if (redirect && (disc != '0)) begin
            state       <= DRAIN;
            discard_cnt <= disc;
          end
        end
        DRAIN: begin
          if (rsp_fire) begin
            discard_cnt <= discard_cnt - CW'(1);
            if (discard_cnt == CW'(1)) begin
              state <= FETCH;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Payload storage; contents are only meaningful under the pointers above.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc[t_wr] <= pc;
    end
    if (push) begin
      q_instr[q_wr] <= imem_rsp_data;
      q_pc[q_wr]    <= tag_pc[t_rd];
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (id_fire) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule
